// File: rtl/simd_pkg.sv
// Shared lane definitions for the SIMD add/subtract paths.
// Lane width is fixed here; modules using lane_res_t must be built with W == SIMD_W.
package simd_pkg;

  localparam int SIMD_N = 4;
  localparam int SIMD_W = 10;

  typedef struct packed {
    logic [SIMD_W-1:0] value;
    logic              borrow;
  } lane_res_t;

  // Subtract at W+1 bits so the top bit is the borrow; optionally clamp to 0.
  function automatic lane_res_t sub_lane(input logic [SIMD_W-1:0] a,
                                         input logic [SIMD_W-1:0] b,
                                         input logic              sat);
    logic [SIMD_W:0] d;
    lane_res_t       r;
    d        = {1'b0, a} - {1'b0, b};
    r.borrow = d[SIMD_W];
    r.value  = (sat && d[SIMD_W]) ? '0 : d[SIMD_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/simd_pipe_reg.sv
// One valid/ready register slice with a parameterised payload.
// Full-throughput: accepts a new word in the same cycle the held word leaves.
module simd_pipe_reg #(
  parameter int PW       = 8,
  parameter bit RST_DATA = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          vld_p0;
  logic [PW-1:0] data_p0;
  logic          load;

  // Held low during reset so nothing is accepted and then silently dropped.
  assign in_ready  = (~vld_p0 | out_ready) & ~rst;
  assign load      = in_valid & in_ready;
  assign out_valid = vld_p0;
  assign out_data  = data_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else if (load) begin
      vld_p0 <= 1'b1;
    end else if (out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  generate
    if (RST_DATA) begin : g_rst_data
      always_ff @(posedge clk) begin
        if (rst) begin
          data_p0 <= '0;
        end else if (load) begin
          data_p0 <= in_data;
        end
      end
    end else begin : g_plain_data
      always_ff @(posedge clk) begin
        if (load) begin
          data_p0 <= in_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/parallel_subtractor.sv
// N-lane SIMD subtractor with valid/ready stream, per-lane borrow,
// optional unsigned saturation and sticky underflow flags. Two register stages.
import simd_pkg::*;

(* use_dsp = "simd" *)
module parallel_subtractor #(
  parameter int  N     = SIMD_N,
  parameter int  W     = SIMD_W,
  parameter type DTYPE = logic,
  parameter bit  SAT   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  DTYPE [W-1:0]   a [N],
  input  DTYPE [W-1:0]   b [N],
  output logic           out_valid,
  input  logic           out_ready,
  output DTYPE [W-1:0]   diff [N],
  output logic [N-1:0]   borrow,
  input  logic           clr_sticky,
  output logic [N-1:0]   sticky_uf
);

  localparam int P1W = 2 * N * W;
  localparam int P2W = N * W + N;

  logic [P1W-1:0] ops_p0;
  logic [P1W-1:0] ops_p1;
  logic           vld_p1;
  logic           rdy_p2;
  logic [P2W-1:0] res_p1;
  logic [P2W-1:0] res_p2;
  logic           vld_p2;
  logic           load_p2;

  always_comb begin
    ops_p0 = '0;
    for (int i = 0; i < N; i++) begin
      ops_p0[i*W +: W]       = a[i];
      ops_p0[(N+i)*W +: W]   = b[i];
    end
  end

  // ---- stage 1: operand capture ----
  simd_pipe_reg #(.PW(P1W), .RST_DATA(1'b0)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (ops_p0),
    .out_valid (vld_p1),
    .out_ready (rdy_p2),
    .out_data  (ops_p1)
  );

  always_comb begin
    lane_res_t r;
    res_p1 = '0;
    for (int i = 0; i < N; i++) begin
      r = sub_lane(ops_p1[i*W +: W], ops_p1[(N+i)*W +: W], SAT);
      res_p1[i*W +: W] = r.value;
      res_p1[N*W + i]  = r.borrow;
    end
  end

  // ---- stage 2: result ----
  simd_pipe_reg #(.PW(P2W), .RST_DATA(1'b1)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p1),
    .in_ready  (rdy_p2),
    .in_data   (res_p1),
    .out_valid (vld_p2),
    .out_ready (out_ready),
    .out_data  (res_p2)
  );

  assign out_valid = vld_p2;
  assign borrow    = res_p2[N*W +: N];
  assign load_p2   = vld_p1 & rdy_p2;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      diff[i] = res_p2[i*W +: W];
    end
  end

  // A borrow loading this cycle beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_uf <= '0;
    end else begin
      sticky_uf <= (clr_sticky ? '0 : sticky_uf) | (load_p2 ? res_p1[N*W +: N] : '0);
    end
  end

endmodule
